// File: rtl/clocked_demux_rx.sv
// Receive side of a 2:1 bit-interleaved link: rebuilds ch0/ch1 words from a serial
// stream framed by sync and presents each completed pair through a valid/ready holding stage.
module clocked_demux_rx #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_d_in,
    input  logic             i_in_valid,
    input  logic             i_sync,
    output logic [WIDTH-1:0] o_d_out0,
    output logic [WIDTH-1:0] o_d_out1,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_overrun,
    output logic             o_sync_err
);
    // state | meaning
    // HUNT  | no frame alignment yet; bits are dropped until a consumed bit carries sync
    // RECV  | aligned; r_cnt is the frame index of the next consumed bit
    localparam logic HUNT = 1'b0;
    localparam logic RECV = 1'b1;

    localparam int              CW       = $clog2(2 * WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(2 * WIDTH - 1);

    logic             r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sh0;
    logic [WIDTH-1:0] r_sh1;
    logic [WIDTH-1:0] r_d_out0;
    logic [WIDTH-1:0] r_d_out1;
    logic             r_out_valid;
    logic             r_overrun;
    logic             r_sync_err;

    logic             w_restart;
    logic             w_accept;
    logic             w_mid_sync;
    logic [CW-1:0]    w_idx;
    logic             w_done;

    // A sync bit always restarts the frame at index 0, whether hunting or realigning.
    always_comb begin
        w_accept   = i_in_valid && (r_state == RECV || i_sync);
        w_restart  = i_in_valid && i_sync;
        w_mid_sync = i_in_valid && i_sync && (r_state == RECV) && (r_cnt != '0);
        w_idx      = w_restart ? '0 : r_cnt;
        w_done     = w_accept && (w_idx == CNT_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= HUNT;
            r_cnt       <= '0;
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_d_out0    <= '0;
            r_d_out1    <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_sync_err <= w_mid_sync;

            if (w_accept) begin
                r_state <= RECV;
                r_cnt   <= (w_idx == CNT_LAST) ? '0 : w_idx + 1'b1;
                if (w_idx[0] == 1'b0) begin
                    r_sh0 <= {r_sh0[WIDTH-2:0], i_d_in};
                end else begin
                    r_sh1 <= {r_sh1[WIDTH-2:0], i_d_in};
                end
            end

            // Last frame bit is always a ch1 bit, so ch1 is taken straight from the shift input.
            if (w_done) begin
                r_d_out0    <= r_sh0;
                r_d_out1    <= {r_sh1[WIDTH-2:0], i_d_in};
                r_out_valid <= 1'b1;
                if (r_out_valid && !i_out_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_d_out0    = r_d_out0;
    assign o_d_out1    = r_d_out1;
    assign o_out_valid = r_out_valid;
    assign o_overrun   = r_overrun;
    assign o_sync_err  = r_sync_err;

endmodule

// File: doc/clocked_demux_rx.md
CLOCKED_DEMUX_RX -- requirements
Module: clocked_demux_rx

Interface
REQ-001 Parameter: WIDTH, default 8, bits per channel word; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 d_in  input  1  interleaved serial stream from the 2:1 transmit mux; even slots carry ch0, odd slots carry ch1.
REQ-005 in_valid  input  1  qualifies d_in and sync; a bit is consumed only when in_valid=1.
REQ-006 sync  input  1  frame-start marker, coincident with the first ch0 bit of a frame.
REQ-007 d_out0  output  WIDTH  last complete ch0 word.
REQ-008 d_out1  output  WIDTH  last complete ch1 word.
REQ-009 out_valid  output  1  d_out0/d_out1 hold an unacknowledged frame.
REQ-010 out_ready  input  1  consumer acknowledge; transfer occurs when out_valid=1 and out_ready=1.
REQ-011 overrun  output  1  sticky: a completed frame overwrote an unacknowledged one.
REQ-012 sync_err  output  1  one-cycle pulse: sync seen mid-frame.

Function
REQ-013 FSM states SHALL be HUNT and RECV; HUNT discards all bits until a consumed bit has sync=1.
REQ-014 HUNT -> RECV on a consumed bit with sync=1; that bit SHALL be frame bit 0.
REQ-015 Frame SHALL be 2*WIDTH consumed bits; bit index k even -> ch0, k odd -> ch1; each channel MSB first.
REQ-016 A bit counter 0..2*WIDTH-1 SHALL advance only on consumed bits; in_valid=0 stalls it with no data loss.
REQ-017 On consuming bit 2*WIDTH-1: counter wraps to 0, FSM stays in RECV, next consumed bit is frame bit 0 of the next frame with or without sync.
REQ-018 d_out0/d_out1 SHALL update and out_valid SHALL be 1 on the cycle after the last frame bit is consumed (latency 1 clk); partial shift contents SHALL never appear on d_out*.
REQ-019 out_valid SHALL stay 1, with d_out* stable, until a cycle with out_ready=1 and no simultaneous frame completion; it then clears.
REQ-020 Frame completion while out_valid=1 and out_ready=0: d_out* overwritten, out_valid stays 1, overrun set to 1.
REQ-021 Frame completion while out_valid=1 and out_ready=1: d_out* loaded, out_valid stays 1, overrun unchanged.
REQ-022 overrun SHALL clear only by reset.
REQ-023 Consumed bit with sync=1 in RECV at counter!=0: sync_err pulses 1 for one cycle, partial frame discarded, that bit taken as frame bit 0.
REQ-024 sync with in_valid=0 SHALL be ignored.
REQ-025 sync=1 at counter=0 in RECV is legal realignment; no sync_err.

Reset
REQ-026 With reset=0 at a clk edge: FSM=HUNT, counter=0, shift registers=0, d_out0=0, d_out1=0, out_valid=0, overrun=0, sync_err=0.
REQ-027 Reset mid-frame SHALL discard the partial frame and any pending unacknowledged word; first frame after reset requires sync.
REQ-028 Inputs SHALL be ignored in any cycle reset=0.

Verification (WIDTH=8)
REQ-029 Reset, then 16 consumed bits with sync on bit 0, ch0=0xA5, ch1=0x3C, out_ready=0 -> one cycle after bit 15: d_out0=0xA5, d_out1=0x3C, out_valid=1, overrun=0.
REQ-030 Same frame with in_valid=0 inserted every third cycle -> identical outputs, latency 1 clk after the last consumed bit.
REQ-031 Bits without sync, then sync frame ch0=0xFF ch1=0x00 -> pre-sync bits discarded, d_out0=0xFF, d_out1=0x00.
REQ-032 Two back-to-back frames (0x12/0x34 then 0x56/0x78), out_ready=0 throughout -> d_out0=0x56, d_out1=0x78, out_valid=1, overrun=1; out_ready=1 one cycle -> out_valid=0, overrun stays 1.
REQ-033 sync re-asserted at bit index 6 -> sync_err=1 for one cycle, following 16 bits form the frame, no out_valid for the aborted frame.
REQ-034 reset=0 at bit index 9, then full sync frame 0xC3/0x81 -> all outputs 0 after reset, then d_out0=0xC3, d_out1=0x81, out_valid=1, overrun=0.
